// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register-file write port between the
// in-order pipeline and a long-latency unit buffered in a one-entry slot.
module wb_port_arbiter #(
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pipe_valid,
   input  logic             pipe_reg_write,
   input  logic             pipe_mem_to_reg,
   input  logic [4:0]       pipe_rd,
   input  logic [XLEN-1:0]  pipe_result,
   input  logic [XLEN-1:0]  pipe_read_data,
   output logic             pipe_stall,
   input  logic             lu_valid,
   input  logic [4:0]       lu_rd,
   input  logic [XLEN-1:0]  lu_data,
   output logic             lu_ready,
   output logic             pend_valid,
   output logic [4:0]       pend_rd,
   output logic             wb_reg_write,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic [1:0]       dbg_state,
   output logic [CNT_W-1:0] dbg_wait_cnt
);

   // Handshake: an lu result transfers on a rising clk edge where
   // lu_valid && lu_ready; lu_ready depends only on registered state.

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_FORCE = 2'd2
   } pend_state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   pend_state_t      state;
   logic [XLEN-1:0]  pend_data;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic             pipe_need;
   logic             force_pend;
   logic             grant_pend;
   logic             grant_pipe;
   logic             accept;
   logic [XLEN-1:0]  pipe_wdata;

   assign pend_valid   = (state != ST_EMPTY);
   assign force_pend   = (state == ST_FORCE);
   assign lu_ready     = ~pend_valid;
   assign accept       = lu_valid & lu_ready;

   assign pipe_need    = pipe_valid & pipe_reg_write & (pipe_rd != 5'd0);
   assign grant_pend   = pend_valid & (force_pend | ~pipe_need);
   assign grant_pipe   = pipe_need & ~force_pend;
   assign pipe_stall   = force_pend & pipe_need;
   assign pipe_wdata   = pipe_mem_to_reg ? pipe_read_data : pipe_result;

   assign dbg_state    = state;
   assign dbg_wait_cnt = wait_cnt;

   // Counts lost arbitration rounds of the current pending entry.
   always_comb begin
      cnt_nxt = wait_cnt;
      if (!pend_valid || grant_pend) begin
         cnt_nxt = '0;
      end else if (grant_pipe && (wait_cnt < LIMIT)) begin
         cnt_nxt = wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_EMPTY;
         pend_rd      <= 5'd0;
         pend_data    <= '0;
         wait_cnt     <= '0;
         wb_reg_write <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= '0;
      end else begin
         wait_cnt <= cnt_nxt;

         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state     <= ST_FULL;
                  pend_rd   <= lu_rd;
                  pend_data <= lu_data;
               end
            end
            ST_FULL, ST_FORCE: begin
               // A drain frees the slot only from the next cycle on.
               if (grant_pend) begin
                  state <= ST_EMPTY;
               end else if (cnt_nxt >= LIMIT) begin
                  state <= ST_FORCE;
               end else begin
                  state <= ST_FULL;
               end
            end
            default: state <= ST_EMPTY;
         endcase

         if (grant_pend) begin
            wb_reg_write <= (pend_rd != 5'd0);
            wb_rd        <= pend_rd;
            wb_data      <= pend_data;
         end else if (grant_pipe) begin
            wb_reg_write <= 1'b1;
            wb_rd        <= pipe_rd;
            wb_data      <= pipe_wdata;
         end else begin
            wb_reg_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: cycle table with expected write-back pushed to a
// queue, a mid-operation reset sequence, and random pipeline-only traffic.
module tb_wb_port_arbiter;

   localparam int XLEN = 64;
   localparam int CW   = 8;
   localparam int EW   = 1 + 5 + XLEN;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pipe_valid, pipe_reg_write, pipe_mem_to_reg;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_result, pipe_read_data;
   logic            pipe_stall;
   logic            lu_valid;
   logic [4:0]      lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            lu_ready, pend_valid;
   logic [4:0]      pend_rd;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [1:0]      dbg_state;
   logic [CW-1:0]   dbg_wait_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic            pv, rw, m2r;
      logic [4:0]      rd;
      logic [XLEN-1:0] res, rdat;
      logic            lv;
      logic [4:0]      lrd;
      logic [XLEN-1:0] ldat;
      logic            e_stall, e_lready, e_pvld;
      logic [4:0]      e_prd;
      logic            e_wr;
      logic [4:0]      e_wrd;
      logic [XLEN-1:0] e_wdat;
   } vec_t;

   vec_t vecs[$];

   wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write),
      .pipe_mem_to_reg(pipe_mem_to_reg), .pipe_rd(pipe_rd),
      .pipe_result(pipe_result), .pipe_read_data(pipe_read_data),
      .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .pend_valid(pend_valid), .pend_rd(pend_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t row(
      input logic pv, input logic rw, input logic m2r, input logic [4:0] rd,
      input logic [XLEN-1:0] res, input logic [XLEN-1:0] rdat,
      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
      input logic es, input logic elr, input logic epv, input logic [4:0] eprd,
      input logic ewr, input logic [4:0] ewrd, input logic [XLEN-1:0] ewd);
      vec_t t;
      t.pv = pv; t.rw = rw; t.m2r = m2r; t.rd = rd; t.res = res; t.rdat = rdat;
      t.lv = lv; t.lrd = lrd; t.ldat = ldat;
      t.e_stall = es; t.e_lready = elr; t.e_pvld = epv; t.e_prd = eprd;
      t.e_wr = ewr; t.e_wrd = ewrd; t.e_wdat = ewd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t t);
      pipe_valid      = t.pv;
      pipe_reg_write  = t.rw;
      pipe_mem_to_reg = t.m2r;
      pipe_rd         = t.rd;
      pipe_result     = t.res;
      pipe_read_data  = t.rdat;
      lu_valid        = t.lv;
      lu_rd           = t.lrd;
      lu_data         = t.ldat;
   endtask

   task automatic check_wb();
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL wb_queue: got empty queue expected an entry");
      end else begin
         e = exp_q.pop_front();
         chk("wb", {wb_reg_write, wb_rd, wb_data}, e);
      end
      chk("x0_guard", EW'(wb_reg_write && (wb_rd == 5'd0)), EW'(0));
   endtask

   // Drive one cycle: combinational checks mid-cycle, write-back after the edge.
   task automatic apply(input vec_t t);
      drive(t);
      #3;
      chk("pipe_stall", EW'(pipe_stall), EW'(t.e_stall));
      chk("lu_ready", EW'(lu_ready), EW'(t.e_lready));
      chk("pend_valid", EW'(pend_valid), EW'(t.e_pvld));
      if (t.e_pvld) chk("pend_rd", EW'(pend_rd), EW'(t.e_prd));
      exp_q.push_back({t.e_wr, t.e_wrd, t.e_wdat});
      @(posedge clk);
      #1;
      check_wb();
   endtask

   initial begin
      logic [4:0]      m_rd;
      logic [XLEN-1:0] m_data;
      vec_t            t;

      rst_n = 1'b0;
      drive(row(0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb", {wb_reg_write, wb_rd, wb_data}, EW'(0));
      chk("rst_pend_valid", EW'(pend_valid), EW'(0));
      chk("rst_lu_ready", EW'(lu_ready), EW'(1));
      rst_n = 1'b1;

      //            pv rw m2 rd  res      rdat   lv lrd ldat      st lr pv prd  wr wrd wdat
      vecs.push_back(row(1,1,1, 5, 64'h0,    64'hAA, 0, 0, 64'h0,    0,1,0, 0,   1, 5, 64'hAA));
      vecs.push_back(row(1,1,0, 5, 64'h1234, 64'hAA, 0, 0, 64'h0,    0,1,0, 0,   1, 5, 64'h1234));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,1,0, 0,   0, 5, 64'h1234));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  1, 7, 64'h55,   0,1,0, 0,   0, 5, 64'h1234));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,0,1, 7,   1, 7, 64'h55));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,1,0, 0,   0, 7, 64'h55));
      vecs.push_back(row(1,1,0, 3, 64'h30,   64'h0,  1, 9, 64'h99,   0,1,0, 0,   1, 3, 64'h30));
      vecs.push_back(row(1,1,0, 4, 64'h40,   64'h0,  0, 0, 64'h0,    0,0,1, 9,   1, 4, 64'h40));
      vecs.push_back(row(1,1,0, 5, 64'h50,   64'h0,  0, 0, 64'h0,    0,0,1, 9,   1, 5, 64'h50));
      vecs.push_back(row(1,1,0, 6, 64'h60,   64'h0,  0, 0, 64'h0,    0,0,1, 9,   1, 6, 64'h60));
      vecs.push_back(row(1,1,0, 8, 64'h80,   64'h0,  0, 0, 64'h0,    0,0,1, 9,   1, 8, 64'h80));
      vecs.push_back(row(1,1,0,10, 64'hA0,   64'h0,  0, 0, 64'h0,    1,0,1, 9,   1, 9, 64'h99));
      vecs.push_back(row(1,1,0,10, 64'hA0,   64'h0,  0, 0, 64'h0,    0,1,0, 0,   1,10, 64'hA0));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  1,11, 64'hBB,   0,1,0, 0,   0,10, 64'hA0));
      vecs.push_back(row(1,1,0,12, 64'hC0,   64'h0,  0, 0, 64'h0,    0,0,1,11,   1,12, 64'hC0));
      vecs.push_back(row(1,1,0,13, 64'hD0,   64'h0,  0, 0, 64'h0,    0,0,1,11,   1,13, 64'hD0));
      vecs.push_back(row(1,0,0,14, 64'hE0,   64'h0,  0, 0, 64'h0,    0,0,1,11,   1,11, 64'hBB));
      vecs.push_back(row(1,1,0, 1, 64'h11,   64'h0,  1,15, 64'hF5,   0,1,0, 0,   1, 1, 64'h11));
      vecs.push_back(row(1,1,0, 2, 64'h21,   64'h0,  0, 0, 64'h0,    0,0,1,15,   1, 2, 64'h21));
      vecs.push_back(row(1,1,0, 2, 64'h22,   64'h0,  0, 0, 64'h0,    0,0,1,15,   1, 2, 64'h22));
      vecs.push_back(row(1,1,0, 2, 64'h23,   64'h0,  0, 0, 64'h0,    0,0,1,15,   1, 2, 64'h23));
      vecs.push_back(row(1,1,0, 2, 64'h24,   64'h0,  0, 0, 64'h0,    0,0,1,15,   1, 2, 64'h24));
      vecs.push_back(row(1,1,0, 3, 64'h31,   64'h0,  0, 0, 64'h0,    1,0,1,15,   1,15, 64'hF5));
      vecs.push_back(row(1,1,0, 3, 64'h31,   64'h0,  0, 0, 64'h0,    0,1,0, 0,   1, 3, 64'h31));
      vecs.push_back(row(1,1,0, 0, 64'hDEAD, 64'h0,  0, 0, 64'h0,    0,1,0, 0,   0, 3, 64'h31));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  1, 0, 64'h77,   0,1,0, 0,   0, 3, 64'h31));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,0,1, 0,   0, 0, 64'h77));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,1,0, 0,   0, 0, 64'h77));
      vecs.push_back(row(1,1,0, 0, 64'hBAD,  64'h0,  1,20, 64'h2020, 0,1,0, 0,   0, 0, 64'h77));
      vecs.push_back(row(1,1,0, 0, 64'hBAD,  64'h0,  0, 0, 64'h0,    0,0,1,20,   1,20, 64'h2020));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,1,0, 0,   0,20, 64'h2020));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  1,21, 64'h21,   0,1,0, 0,   0,20, 64'h2020));
      vecs.push_back(row(1,1,0, 1, 64'h1,    64'h0,  1,22, 64'h22,   0,0,1,21,   1, 1, 64'h1));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,0,1,21,   1,21, 64'h21));
      vecs.push_back(row(0,0,0, 0, 64'h0,    64'h0,  0, 0, 64'h0,    0,1,0, 0,   0,21, 64'h21));
      vecs.push_back(row(1,1,0, 6, 64'h66,   64'h0,  1,25, 64'h2525, 0,1,0, 0,   1, 6, 64'h66));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Pending entry full and a pipe write in flight when reset hits mid-cycle.
      drive(row(1,1,0, 7, 64'h77, 64'h0, 0, 0, 64'h0, 0,0,0,0, 0,0,0));
      #3;
      chk("pre_rst_pend_valid", EW'(pend_valid), EW'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wb", {wb_reg_write, wb_rd, wb_data}, EW'(0));
      chk("mid_rst_pend", {pend_valid, pend_rd}, EW'(0));
      chk("mid_rst_stall", EW'(pipe_stall), EW'(0));
      chk("mid_rst_state", {dbg_state, dbg_wait_cnt}, EW'(0));
      @(posedge clk);
      #1;
      chk("in_rst_wb", {wb_reg_write, wb_rd, wb_data}, EW'(0));
      rst_n = 1'b1;
      drive(row(0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
      #3;
      chk("post_rst_lu_ready", EW'(lu_ready), EW'(1));
      chk("post_rst_pend_valid", EW'(pend_valid), EW'(0));
      @(posedge clk);
      #1;
      chk("post_rst_wb", {wb_reg_write, wb_rd, wb_data}, EW'(0));

      // Random pipeline-only traffic against a hold-register model.
      m_rd   = 5'd0;
      m_data = '0;
      for (int i = 0; i < 24; i++) begin
         t = row(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 0, 0, 64'h0, 0,1,0,0, 0,0,0);
         if (t.pv && t.rw && (t.rd != 5'd0)) begin
            m_rd   = t.rd;
            m_data = t.m2r ? t.rdat : t.res;
            t.e_wr = 1'b1;
         end else begin
            t.e_wr = 1'b0;
         end
         t.e_wrd  = m_rd;
         t.e_wdat = m_data;
         apply(t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish within 200000");
      $fatal(1);
   end

endmodule
